// File: rtl/ddr_rw_sched_if.sv
// Command/status bundle for the DDR read/write data-phase scheduler.
// turn_err exists only when DDR_RW_TURNAROUND_CHECK_EN is defined.
interface ddr_rw_sched_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT_W = 6
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             cas_rdy;
  logic [2:0]       cas_req;
  logic [LAT_W-1:0] CL;
  logic [LAT_W-1:0] CWL;
  logic [LAT_W-1:0] AL;
  logic [LAT_W-1:0] RD_PRE;
  logic [LAT_W-1:0] WR_PRE;
  logic             rd_rdy;
  logic             rda_rdy;
  logic             wr_rdy;
  logic             wra_rdy;
  logic             rw_done;
  logic             data_idle;
  logic [CNT_W-1:0] q_count;
  logic             full;
  logic             overflow;
  logic             collision;
`ifdef DDR_RW_TURNAROUND_CHECK_EN
  logic             turn_err;
`endif

  modport master (
    output cas_rdy, cas_req, CL, CWL, AL, RD_PRE, WR_PRE,
    input  rd_rdy, rda_rdy, wr_rdy, wra_rdy, rw_done, data_idle,
           q_count, full, overflow, collision
`ifdef DDR_RW_TURNAROUND_CHECK_EN
           , turn_err
`endif
  );

  modport slave (
    input  cas_rdy, cas_req, CL, CWL, AL, RD_PRE, WR_PRE,
    output rd_rdy, rda_rdy, wr_rdy, wra_rdy, rw_done, data_idle,
           q_count, full, overflow, collision
`ifdef DDR_RW_TURNAROUND_CHECK_EN
           , turn_err
`endif
  );
endinterface

// File: rtl/ddr_rw_sched.sv
// DDR read/write data-phase scheduler: in-order CAS queue with per-entry countdowns.
// Optional read/write turnaround check enabled by DDR_RW_TURNAROUND_CHECK_EN.
module ddr_rw_sched #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LAT_W        = 6,
  parameter int unsigned BURST_CYCLES = 4
`ifdef DDR_RW_TURNAROUND_CHECK_EN
  , parameter int unsigned TURN_GAP   = 2
`endif
) (
  input logic           CK_t,
  input logic           reset,
  ddr_rw_sched_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DW    = LAT_W + 2;
  localparam int unsigned BC_W  = (BURST_CYCLES > 2) ? $clog2(BURST_CYCLES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_type [DEPTH];
  logic [LAT_W-1:0] r_cnt  [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [BC_W-1:0]  r_burst, w_burst_nxt;
  logic             r_rd_rdy, r_rda_rdy, r_wr_rdy, r_wra_rdy;
  logic             r_data_idle, r_full, r_overflow, r_collision;
  logic             w_code_ok, w_is_wr, w_full, w_due, w_fire, w_coll, w_push, w_ovf;
  logic [DW-1:0]    w_raw;
  logic [LAT_W-1:0] w_delay;
  logic [3:0]       w_stb_nxt;

  // Command decode and latency: negative results clamp to 0, oversize saturates
  always_comb begin
    w_code_ok = (bus.cas_req >= 3'd1) && (bus.cas_req <= 3'd4);
    w_is_wr   = (bus.cas_req >= 3'd3);
    if (w_is_wr) w_raw = DW'(bus.CWL) + DW'(bus.AL) - DW'(bus.WR_PRE);
    else         w_raw = DW'(bus.CL)  + DW'(bus.AL) - DW'(bus.RD_PRE);
    if (w_raw[DW-1])      w_delay = '0;
    else if (w_raw[LAT_W]) w_delay = '1;
    else                   w_delay = w_raw[LAT_W-1:0];
  end

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_due       = (r_count != '0) && (r_cnt[r_head] == '0);
  assign w_push      = bus.cas_rdy && w_code_ok && (!w_full || w_fire);
  assign w_ovf       = bus.cas_rdy && w_code_ok && w_full && !w_fire;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_fire);

  // Bus FSM: state register
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Bus FSM: next state; a due head inside a burst waits and flags a collision
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_fire      = 1'b0;
    w_coll      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_due) begin
          w_fire      = 1'b1;
          w_state_nxt = S_BURST;
          w_burst_nxt = BC_W'(BURST_CYCLES - 1);
        end
      end
      S_BURST: begin
        if (r_burst != '0) begin
          w_burst_nxt = r_burst - BC_W'(1);
          w_coll      = w_due;
        end else if (w_due) begin
          w_fire      = 1'b1;
          w_burst_nxt = BC_W'(BURST_CYCLES - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus FSM: outputs (strobe selected by head type)
  always_comb begin
    w_stb_nxt = '0;
    if (w_fire) w_stb_nxt[r_type[r_head]] = 1'b1;
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      {r_wra_rdy, r_wr_rdy, r_rda_rdy, r_rd_rdy} <= '0;
      r_data_idle <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      {r_wra_rdy, r_wr_rdy, r_rda_rdy, r_rd_rdy} <= w_stb_nxt;
      r_data_idle <= (w_state_nxt == S_IDLE);
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_overflow  <= r_overflow | w_ovf;
      r_collision <= r_collision | w_coll;
    end
  end

  // Circular queue; every live countdown runs, the new tail entry starts next edge
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_cnt[i]  <= '0;
        r_type[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - LAT_W'(1);
      end
      if (w_push) begin
        r_cnt[r_tail]  <= w_delay;
        r_type[r_tail] <= 2'(bus.cas_req - 3'd1);
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_fire) r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  assign bus.rd_rdy    = r_rd_rdy;
  assign bus.rda_rdy   = r_rda_rdy;
  assign bus.wr_rdy    = r_wr_rdy;
  assign bus.wra_rdy   = r_wra_rdy;
  assign bus.data_idle = r_data_idle;
  assign bus.q_count   = r_count;
  assign bus.full      = r_full;
  assign bus.overflow  = r_overflow;
  assign bus.collision = r_collision;
  assign bus.rw_done   = (r_count == '0) && r_data_idle;

`ifdef DDR_RW_TURNAROUND_CHECK_EN
  localparam int unsigned GAP_W = $clog2(TURN_GAP + 2);
  localparam int unsigned GW1   = GAP_W + 1;

  logic [GAP_W-1:0] r_gap;
  logic [GW1-1:0]   w_gap;
  logic             r_last_wr, r_have_prev, r_turn_err, w_turn;

  // Idle cycles since the last burst ended, counting the current decision cycle
  always_comb begin
    w_gap  = (r_state == S_IDLE) ? GW1'(r_gap) + GW1'(1) : '0;
    w_turn = w_fire && r_have_prev && (r_type[r_head][1] != r_last_wr) &&
             (w_gap < GW1'(TURN_GAP));
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_gap       <= '0;
      r_last_wr   <= 1'b0;
      r_have_prev <= 1'b0;
      r_turn_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (r_gap < GAP_W'(TURN_GAP)) r_gap <= r_gap + GAP_W'(1);
      end else begin
        r_gap <= '0;
      end
      if (w_fire) begin
        r_last_wr   <= r_type[r_head][1];
        r_have_prev <= 1'b1;
      end
      if (w_turn) r_turn_err <= 1'b1;
    end
  end

  assign bus.turn_err = r_turn_err;
`endif
endmodule
